mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Sequencer that drives the select lines of an N:1 data multiplexer (MUX8_1-class, N = 2^SEL_W) and consumes its output. It steps through every channel in order, waits a programmable settle time per channel, samples the single-bit mux output, and assembles the channel values into an N-bit frame. The frame is handed downstream over a valid/ready handshake. The block sits around the mux: `sel` feeds the mux, and `mux_y` returns from it.

## Interface
- `SEL_W`, default 3: select width; N = 2^SEL_W channels.
- `SETTLE`, default 1: extra cycles `sel` is held before sampling (0 allowed).

- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request one scan; accepted only in IDLE.
- `sel` output SEL_W: channel select to mux.
- `mux_y` input 1: mux output for current `sel`.
- `busy` output 1: high whenever state ≠ IDLE.
- `frame` output N: completed frame; bit i = value of channel i.
- `frame_valid` output 1: `frame` holds an unconsumed frame.
- `frame_ready` input 1: downstream accepts frame when high with `frame_valid`.
- `overrun` output 1: sticky; a frame was overwritten before it was consumed.

## Operation
- States: IDLE, SCAN, HOLD.
  - HOLD is present only without the macro described under Configuration.
- Reset values: `sel`=0, `frame`=0, `frame_valid`=0, `busy`=0, `overrun`=0. State is IDLE. Settle counter and shadow register are cleared.
- IDLE, with `start`=1:
  - Next state SCAN.
  - `sel`=0, settle counter=0.
- SCAN:
  - Each channel occupies SETTLE+1 cycles.
  - On the last of those cycles, `mux_y` is written into shadow bit `sel`.
  - If `sel` < N−1: `sel` increments and the counter resets.
  - If `sel` = N−1: the full shadow, including the bit being sampled this cycle, is copied to `frame`. `frame_valid` is set, state goes to HOLD, and `sel` returns to 0.
- HOLD:
  - `frame_valid` and `frame_ready` both 1 → `frame_valid` clears and state goes to IDLE on that edge.
  - `start` is ignored in HOLD, including the handshake cycle.
- `frame` changes only on frame completion. It is never partially updated.
- `start` is ignored while `busy`=1.
- Counter width is max(1, clog2(SETTLE+1)). `sel` never exceeds N−1.
- When `rst_n` is low mid-scan or in HOLD, everything returns to reset values on that edge. The partial frame is discarded.

## Timing
- With `start` accepted at edge E0, channel i is sampled at edge E0 + (i+1)·(SETTLE+1).
- `frame_valid` rises at edge E0 + N·(SETTLE+1). With defaults this is E0 + 16.
- With SETTLE=0, `sel` advances every cycle, giving a latency of N cycles.
- `sel` is registered. The mux path is purely combinational, so `mux_y` is valid in the same cycle `sel` changes. SETTLE covers external settling.
- `frame_valid` stays high, with `frame` stable, until the handshake edge.
- `busy` drops on the handshake edge, and a new `start` is accepted from the next cycle.

## Configuration
- Macro: `MUX_SCAN_CONT_EN`.
- Undefined:
  - Single-shot operation as described above.
  - `overrun` is tied 0.
- Defined (continuous scan):
  - HOLD does not exist and `start` is ignored.
  - SCAN is entered on the first cycle after `rst_n` deasserts, and scanning repeats back-to-back: after channel N−1, `sel` returns to 0 with no gap.
  - New frame completes while `frame_valid`=1 and `frame_ready`=0: `frame` is overwritten, `frame_valid` stays 1, and `overrun` sets. `overrun` stays set until reset.
  - Handshake on the same edge as a completion: the new frame is loaded, `frame_valid` stays 1, and `overrun` does not set.
  - `busy`=1 whenever out of reset.

## Test plan
- Defaults; mux inputs ch0..ch7 = 0,1,0,1,0,1,0,1; `start` pulse at E0 → `sel` steps 0..7 holding 2 cycles each, `frame_valid` at E0+16, `frame`=8'hAA.
- Hold `frame_ready`=0 for 10 cycles after completion while pulsing `start` → `frame`=8'hAA is held, `busy`=1, no new scan. Then assert `frame_ready` for 1 cycle → `frame_valid`=0, `busy`=0.
- SETTLE=0; inputs all 1; `start` → `frame_valid` at E0+8, `frame`=8'hFF.
- Assert `rst_n`=0 at E0+7 → `sel`=0, `frame`=0, `frame_valid`=0, `busy`=0. A subsequent `start` gives a correct full frame.
- `MUX_SCAN_CONT_EN` defined, `frame_ready`=0, inputs changed to 8'h0F pattern mid-scan → frames every 16 cycles. `overrun` rises at the second completion. `frame` shows the latest complete frame, never a mix within one frame boundary.
- `MUX_SCAN_CONT_EN` defined, `frame_ready` pulsed exactly on each completion edge → `frame_valid` stays 1 continuously and `overrun` stays 0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an N:1 single-bit mux. It steps sel over every channel and samples mux_y.
// Latency: frame_valid rises N*(SETTLE+1) cycles after start is accepted.
// Backpressure: single-shot holds the frame until frame_ready; MUX_SCAN_CONT_EN overwrites it and flags overrun.
//
// Optional feature macro: MUX_SCAN_CONT_EN (continuous back-to-back scanning; start is ignored).
module mux_scan_ctrl #(
    parameter int SEL_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    output logic [SEL_W-1:0]        o_sel,
    input  logic                    i_mux_y,
    output logic                    o_busy,
    output logic [(1<<SEL_W)-1:0]   o_frame,
    output logic                    o_frame_valid,
    input  logic                    i_frame_ready,
    output logic                    o_overrun
);
    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_sel;
    logic [N-1:0]       r_shadow;
    logic [N-1:0]       r_frame;
    logic               r_frame_valid;
    logic               r_busy;

    logic               w_sample;
    logic               w_last_ch;
    logic               w_complete;
    logic [N-1:0]       w_full;

    // Last settle cycle of the current channel; the last channel closes the frame.
    assign w_sample   = (r_state == S_SCAN) && (r_cnt == CNT_LAST);
    assign w_last_ch  = (r_sel == SEL_LAST);
    assign w_complete = w_sample && w_last_ch;

    // Shadow with the bit being sampled this cycle merged in, so the frame is copied whole.
    always_comb begin
        w_full        = r_shadow;
        w_full[r_sel] = i_mux_y;
    end

`ifdef MUX_SCAN_CONT_EN
    logic r_overrun;
    logic w_unused;
    assign w_unused  = i_start;
    assign o_overrun = r_overrun;

    // Sticky overrun: a completed frame replaced one that was never consumed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_complete && r_frame_valid && !i_frame_ready) begin
            r_overrun <= 1'b1;
        end
    end
`else
    assign o_overrun = 1'b0;
`endif

    // Scan sequencer: channel stepping, settle counting, sampling and frame hand-off.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_sel         <= '0;
            r_shadow      <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef MUX_SCAN_CONT_EN
                    r_state <= S_SCAN;
                    r_busy  <= 1'b1;
                    r_sel   <= '0;
                    r_cnt   <= '0;
`else
                    if (i_start) begin
                        r_state <= S_SCAN;
                        r_busy  <= 1'b1;
                        r_sel   <= '0;
                        r_cnt   <= '0;
                    end
`endif
                end
                S_SCAN: begin
                    if (w_sample) begin
                        r_shadow[r_sel] <= i_mux_y;
                        r_cnt           <= '0;
                        if (w_last_ch) begin
                            r_frame       <= w_full;
                            r_frame_valid <= 1'b1;
                            r_sel         <= '0;
`ifndef MUX_SCAN_CONT_EN
                            r_state       <= S_HOLD;
`endif
                        end else begin
                            r_sel <= r_sel + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`ifdef MUX_SCAN_CONT_EN
                    // Consumption only clears valid when no new frame lands on the same edge.
                    if (r_frame_valid && i_frame_ready && !w_complete) begin
                        r_frame_valid <= 1'b0;
                    end
`endif
                end
`ifndef MUX_SCAN_CONT_EN
                S_HOLD: begin
                    if (r_frame_valid && i_frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sel         = r_sel;
    assign o_busy        = r_busy;
    assign o_frame       = r_frame;
    assign o_frame_valid = r_frame_valid;
endmodule
